clk_gate_ctrl: RTL and testbench
================================

Name: clk_gate_ctrl

Overview:
Enable controller that drives the E and SE pins of a CLKGATETST-style integrated clock-gating cell. It watches downstream activity and gates the clock after a programmable idle period. It restores the clock on a wake request using a req/rdy handshake that guarantees WAKE_CYCLES of settling before the domain is reported ready. Scan mode forces the clock on through SE.

Parameters:
IDLE_CYCLES, 8, consecutive idle cycles before gating (legal range 1..255)
WAKE_CYCLES, 2, cycles E is held high before rdy asserts after a wake (legal range 1..15)
CNT_W, 8, width of the gating-event counter

Ports:
CK  input  1  free-running clock; all state updates on the rising edge
RN  input  1  reset; synchronous, active-low
busy  input  1  downstream domain activity; 1 = not idle
req  input  1  wake request from the initiator; level-held until rdy is seen
force_on  input  1  software override; keeps the clock ungated
test_mode  input  1  scan mode
E  output  1  functional enable to the gating cell (registered)
SE  output  1  scan enable to the gating cell (registered copy of test_mode)
rdy  output  1  gated domain clocked and stable (registered)
gated  output  1  1 while the clock is gated (registered)
gate_cnt  output  CNT_W  number of entries into GATED, saturating (registered)

Behaviour:
- Reset: RN=0 sampled at a rising CK edge puts the block in RUN. Reset values: E=1, SE=0, rdy=1, gated=0, gate_cnt=0, idle_cnt=0, wake_cnt=0. Reset overrides every other input and also applies mid-WAKE and mid-GATED.
- Definitions: idle = !busy & !req & !force_on. All outputs are flops; no combinational input-to-output paths.
- RUN state: E=1, rdy=1, gated=0.
  - When not idle: idle_cnt is cleared.
  - When idle and idle_cnt < IDLE_CYCLES-1: idle_cnt increments.
  - When idle and idle_cnt == IDLE_CYCLES-1: move to GATED. At that edge E=0, gated=1, rdy=0, and gate_cnt increments (it holds once it reaches 2^CNT_W-1).
  - Result: E falls at the edge that samples the IDLE_CYCLES-th consecutive idle cycle.
- GATED state: E=0, rdy=0, gated=1.
  - Any of req, busy or force_on set moves to WAKE at the next edge. At that edge E=1, gated=0, and wake_cnt loads WAKE_CYCLES-1.
  - busy while GATED is treated as a wake, not an error.
- WAKE state: E=1, rdy=0, gated=0.
  - wake_cnt decrements each cycle. When wake_cnt == 0, move to RUN at the next edge with rdy=1 and idle_cnt=0.
  - rdy therefore rises WAKE_CYCLES edges after E rises. req/busy/force_on changes during WAKE are ignored; there is no return to GATED from WAKE.
- Handshake: the initiator holds req until it samples rdy=1. A request that arrives while in RUN sees rdy=1 immediately (zero-cycle ack). Dropping req early while in WAKE does not abort the wake.
- Scan:
  - SE follows test_mode with one cycle of latency.
  - test_mode=1 forces the next state to RUN from any state (E=1, rdy=1, gated=0, idle_cnt=0, wake_cnt=0).
  - gate_cnt holds while test_mode=1.
  - When test_mode deasserts, the block resumes in RUN with the idle count starting from 0.
- Simultaneous events:
  - Idle expiry and test_mode in the same cycle: test_mode wins and the block does not gate.
  - req and busy together in GATED: one wake only.
  - RN low together with anything: reset wins.
- Width rules:
  - idle_cnt is sized to clog2(IDLE_CYCLES) with a minimum of 1 bit; wake_cnt likewise for WAKE_CYCLES.
  - IDLE_CYCLES=1 gates on the first idle cycle.
  - WAKE_CYCLES=1 gives rdy one edge after E rises.

Test Plan:
(All scenarios use IDLE_CYCLES=4, WAKE_CYCLES=2, CNT_W=8.)
- Reset: drive RN=0 for 2 cycles with random inputs -> E=1, SE=0, rdy=1, gated=0, gate_cnt=0.
- Idle gating: busy=req=force_on=0 from cycle 0 -> E=1 for edges 1-3, E=0/gated=1/rdy=0 after edge 4, gate_cnt=1. Repeat with busy=1 pulsed at cycle 2 -> idle count restarts and E falls at edge 7.
- Wake handshake: from GATED, raise req -> next edge E=1, gated=0; rdy=0 for one more edge, then rdy=1. Drop req -> after 4 more idle cycles, gated again with gate_cnt=2.
- Scan override: in GATED, set test_mode=1 -> next edge SE=1, E=1, rdy=1, gated=0. Hold idle for 10 cycles -> no gating and gate_cnt unchanged. Clear test_mode -> SE=0 next edge, and gating occurs 4 idle cycles later.
- Reset mid-wake: assert RN=0 during WAKE -> next edge RUN state, rdy=1, gate_cnt=0.
- Saturation with CNT_W=2: force 5 gate/wake cycles -> gate_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a CLKGATETST-style clock-gating cell: gates the clock
// after a run of idle cycles, restores it on a wake request with a fixed
// settling period before rdy, and forces the clock on in scan mode.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             busy,
  input  logic             req,
  input  logic             force_on,
  input  logic             test_mode,
  output logic             E,
  output logic             SE,
  output logic             rdy,
  output logic             gated,
  output logic [CNT_W-1:0] gate_cnt
);

  localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_GATED = 2'd1;
  localparam logic [1:0] S_WAKE  = 2'd2;

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state, state_n;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic [WAKE_W-1:0] wake_cnt, wake_n;
  logic [CNT_W-1:0]  gate_cnt_n;
  logic              e_n, rdy_n, gated_n;
  logic              idle;

  assign idle = !busy && !req && !force_on;

  // Next-state, counter and output decode; scan mode overrides everything.
  always_comb begin
    state_n    = state;
    idle_n     = idle_cnt;
    wake_n     = wake_cnt;
    gate_cnt_n = gate_cnt;
    if (test_mode) begin
      state_n = S_RUN;
      idle_n  = '0;
      wake_n  = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (!idle) begin
            idle_n = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_n = S_GATED;
            idle_n  = '0;
            if (gate_cnt != CNT_MAX) gate_cnt_n = gate_cnt + CNT_W'(1);
          end else begin
            idle_n = idle_cnt + IDLE_W'(1);
          end
        end
        S_GATED: begin
          if (busy || req || force_on) begin
            state_n = S_WAKE;
            wake_n  = WAKE_LOAD;
          end
        end
        S_WAKE: begin
          if (wake_cnt == '0) begin
            state_n = S_RUN;
            idle_n  = '0;
          end else begin
            wake_n = wake_cnt - WAKE_W'(1);
          end
        end
        default: begin
          state_n = S_RUN;
          idle_n  = '0;
          wake_n  = '0;
        end
      endcase
    end
    e_n     = (state_n != S_GATED);
    rdy_n   = (state_n == S_RUN);
    gated_n = (state_n == S_GATED);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state    <= S_RUN;
      idle_cnt <= '0;
      wake_cnt <= '0;
      gate_cnt <= '0;
      E        <= 1'b1;
      SE       <= 1'b0;
      rdy      <= 1'b1;
      gated    <= 1'b0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_n;
      wake_cnt <= wake_n;
      gate_cnt <= gate_cnt_n;
      E        <= e_n;
      SE       <= test_mode;
      rdy      <= rdy_n;
      gated    <= gated_n;
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: a cycle model pushes expected outputs to a
// scoreboard when inputs are driven; entries are popped after each edge.
module tb_clk_gate_ctrl;

  localparam int unsigned IDLE = 4;
  localparam int unsigned WAKE = 2;

  logic       CK = 1'b0;
  logic       RN, busy, req, force_on, test_mode;
  logic       E, SE, rdy, gated;
  logic [7:0] gate_cnt;
  logic       E2, SE2, rdy2, gated2;
  logic [1:0] gate_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       e;
    logic       se;
    logic       rdy;
    logic       gated;
    logic [7:0] gc;
    logic [1:0] gc2;
  } exp_t;

  exp_t sb[$];

  // model state: 0 = RUN, 1 = GATED, 2 = WAKE
  int m_state = 0;
  int m_idle_seen = 0;
  int m_wake_left = 0;
  int m_gc = 0;
  int m_gc2 = 0;
  logic m_se = 1'b0;

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
    .CK(CK), .RN(RN), .busy(busy), .req(req), .force_on(force_on),
    .test_mode(test_mode), .E(E), .SE(SE), .rdy(rdy), .gated(gated),
    .gate_cnt(gate_cnt)
  );

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(2)) dut_sat (
    .CK(CK), .RN(RN), .busy(busy), .req(req), .force_on(force_on),
    .test_mode(test_mode), .E(E2), .SE(SE2), .rdy(rdy2), .gated(gated2),
    .gate_cnt(gate_cnt2)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input string fld,
                     input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
    end
  endtask

  // Behavioural model of one rising edge.
  task automatic model(input logic b, input logic r, input logic f,
                       input logic t, input logic n);
    if (!n) begin
      m_state = 0; m_idle_seen = 0; m_wake_left = 0;
      m_gc = 0; m_gc2 = 0; m_se = 1'b0;
    end else begin
      m_se = t;
      if (t) begin
        m_state = 0; m_idle_seen = 0; m_wake_left = 0;
      end else if (m_state == 0) begin
        if (b || r || f) m_idle_seen = 0;
        else begin
          m_idle_seen++;
          if (m_idle_seen >= IDLE) begin
            m_state = 1;
            m_idle_seen = 0;
            if (m_gc < 255) m_gc++;
            if (m_gc2 < 3) m_gc2++;
          end
        end
      end else if (m_state == 1) begin
        if (b || r || f) begin
          m_state = 2;
          m_wake_left = WAKE;
        end
      end else begin
        m_wake_left--;
        if (m_wake_left == 0) begin
          m_state = 0;
          m_idle_seen = 0;
        end
      end
    end
  endtask

  task automatic step(input logic b, input logic r, input logic f,
                      input logic t, input logic n, input string tag);
    exp_t x;
    @(negedge CK);
    busy = b; req = r; force_on = f; test_mode = t; RN = n;
    model(b, r, f, t, n);
    x.tag = tag;
    x.e = (m_state != 1);
    x.se = m_se;
    x.rdy = (m_state == 0);
    x.gated = (m_state == 1);
    x.gc = 8'(m_gc);
    x.gc2 = 2'(m_gc2);
    sb.push_back(x);
    @(posedge CK);
    #1;
    x = sb.pop_front();
    chk(x.tag, "E", {7'd0, E}, {7'd0, x.e});
    chk(x.tag, "SE", {7'd0, SE}, {7'd0, x.se});
    chk(x.tag, "rdy", {7'd0, rdy}, {7'd0, x.rdy});
    chk(x.tag, "gated", {7'd0, gated}, {7'd0, x.gated});
    chk(x.tag, "gate_cnt", gate_cnt, x.gc);
    chk(x.tag, "gate_cnt_sat", {6'd0, gate_cnt2}, {6'd0, x.gc2});
  endtask

  task automatic idle_n(input int k, input logic t, input string tag);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, t, 1'b1, tag);
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    RN = 1'b0; busy = 1'b0; req = 1'b0; force_on = 1'b0; test_mode = 1'b0;

    for (int i = 0; i < 2; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "reset");
    chk("reset_const", "E", {7'd0, E}, 8'd1);
    chk("reset_const", "gate_cnt", gate_cnt, 8'd0);

    idle_n(3, 1'b0, "idle_pre");
    chk("idle_pre_const", "E", {7'd0, E}, 8'd1);
    idle_n(1, 1'b0, "idle_gate");
    chk("idle_gate_const", "gated", {7'd0, gated}, 8'd1);
    chk("idle_gate_const", "gate_cnt", gate_cnt, 8'd1);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "wake_e");
    chk("wake_e_const", "E", {7'd0, E}, 8'd1);
    chk("wake_e_const", "rdy", {7'd0, rdy}, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "wake_settle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "wake_rdy");
    chk("wake_rdy_const", "rdy", {7'd0, rdy}, 8'd1);

    idle_n(2, 1'b0, "restart_a");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "restart_busy");
    idle_n(3, 1'b0, "restart_b");
    chk("restart_const", "E", {7'd0, E}, 8'd1);
    idle_n(1, 1'b0, "restart_gate");
    chk("restart_gate_const", "gate_cnt", gate_cnt, 8'd2);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "req_busy");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "force_on");
    chk("force_const", "gated", {7'd0, gated}, 8'd0);
    idle_n(4, 1'b0, "regate");

    idle_n(10, 1'b1, "scan");
    chk("scan_const", "SE", {7'd0, SE}, 8'd1);
    chk("scan_const", "gate_cnt", gate_cnt, 8'd3);
    idle_n(4, 1'b0, "scan_exit");
    chk("scan_exit_const", "gate_cnt", gate_cnt, 8'd4);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pre_rst_wake");
    step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0,
         "rst_mid_wake");
    chk("rst_mid_wake_const", "rdy", {7'd0, rdy}, 8'd1);
    chk("rst_mid_wake_const", "gate_cnt", gate_cnt, 8'd0);

    idle_n(3, 1'b0, "expiry_tm_a");
    idle_n(1, 1'b1, "expiry_tm");
    chk("expiry_tm_const", "gated", {7'd0, gated}, 8'd0);
    idle_n(4, 1'b0, "expiry_tm_b");

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sat_reset");
    for (int k = 0; k < 5; k++) begin
      idle_n(4, 1'b0, "sat_gate");
      chk("sat_const", "gate_cnt_sat", {6'd0, gate_cnt2}, {6'd0, sat_exp[k]});
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "sat_wake");
    end
    chk("sat_const", "gate_cnt", gate_cnt, 8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
